sbox_sched: RTL and testbench

Time-shares one 32-bit (4-lane) S-box substitution unit between the AES round datapath (128-bit SubBytes, issued as four 32-bit beats) and the key-expansion path (32-bit SubWord, one beat). It arbitrates between the two requesters, sequences the beats, assembles results and signals completion with one-cycle done pulses. The S-box lanes are external combinational logic: this block drives their input word and registers their output word.

---
 rtl/sbox_sched_if.sv | 32 +++
 rtl/sbox_sched.sv | 146 ++++++++++++++
 tb/tb_sbox_sched.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sbox_sched_if.sv
// Handshake and S-box lane bundle for sbox_sched: state/key request ports,
// results with done pulses, and the shared 32-bit S-box lane word.
interface sbox_sched_if;
  logic         s_valid;
  logic [127:0] s_data;
  logic         s_ready;
  logic         s_done;
  logic [127:0] s_result;
  logic         k_valid;
  logic [31:0]  k_word;
  logic         k_ready;
  logic         k_done;
  logic [31:0]  k_result;
  logic [31:0]  sb_in;
  logic [31:0]  sb_out;
  logic         busy;

  modport slave (
    input  s_valid, s_data, k_valid, k_word, sb_out,
    output s_ready, s_done, s_result, k_ready, k_done, k_result, sb_in, busy
  );

  modport master (
    output s_valid, s_data, k_valid, k_word,
    input  s_ready, s_done, s_result, k_ready, k_done, k_result, busy
  );

  modport lanes (
    input  sb_in,
    output sb_out
  );
endinterface

// File: rtl/sbox_sched.sv
// Time-shares one 4-lane S-box between 128-bit SubBytes (four beats) and
// 32-bit SubWord jobs, with round-robin arbitration in IDLE.
module sbox_sched #(
  parameter bit KEY_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  sbox_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S_SUB = 2'd1,
    K_SUB = 2'd2
  } state_e;

  // last_key_q = 1 means the key path won the previous grant.
  localparam logic LAST_KEY_RST = KEY_FIRST ? 1'b0 : 1'b1;

  state_e       state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [127:0] sbuf_q, sbuf_d;
  logic [31:0]  kbuf_q, kbuf_d;
  logic         last_key_q, last_key_d;
  logic [127:0] s_result_q, s_result_d;
  logic [31:0]  k_result_q, k_result_d;
  logic         s_done_q, s_done_d;
  logic         k_done_q, k_done_d;
  logic         s_ready_s, k_ready_s;
  logic [31:0]  sb_in_s;

  function automatic logic [31:0] word_sel(input logic [127:0] d, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = d[127:96];
      2'd1:    w = d[95:64];
      2'd2:    w = d[63:32];
      2'd3:    w = d[31:0];
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic [127:0] word_ins(input logic [127:0] d, input logic [1:0] idx,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = d;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      2'd3:    r[31:0]   = w;
      default: r = d;
    endcase
    return r;
  endfunction

  assign s_ready_s = (state_q == IDLE) && (!bus.k_valid || last_key_q);
  assign k_ready_s = (state_q == IDLE) && (!bus.s_valid || !last_key_q);

  // Next-state, beat sequencing, result assembly and lane drive.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    sbuf_d     = sbuf_q;
    kbuf_d     = kbuf_q;
    last_key_d = last_key_q;
    s_result_d = s_result_q;
    k_result_d = k_result_q;
    s_done_d   = 1'b0;
    k_done_d   = 1'b0;
    sb_in_s    = 32'h0;
    case (state_q)
      IDLE: begin
        if (bus.s_valid && s_ready_s) begin
          sbuf_d     = bus.s_data;
          last_key_d = 1'b0;
          beat_d     = 2'd0;
          state_d    = S_SUB;
        end else if (bus.k_valid && k_ready_s) begin
          kbuf_d     = bus.k_word;
          last_key_d = 1'b1;
          state_d    = K_SUB;
        end else begin
          state_d    = IDLE;
        end
      end
      S_SUB: begin
        sb_in_s    = word_sel(sbuf_q, beat_q);
        s_result_d = word_ins(s_result_q, beat_q, bus.sb_out);
        if (beat_q == 2'd3) begin
          s_done_d = 1'b1;
          beat_d   = 2'd0;
          state_d  = IDLE;
        end else begin
          beat_d   = beat_q + 2'd1;
        end
      end
      K_SUB: begin
        sb_in_s    = kbuf_q;
        k_result_d = bus.sb_out;
        k_done_d   = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        beat_d  = 2'd0;
      end
    endcase
  end

  // State and datapath registers; reset also cancels any in-flight job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      sbuf_q     <= 128'h0;
      kbuf_q     <= 32'h0;
      last_key_q <= LAST_KEY_RST;
      s_result_q <= 128'h0;
      k_result_q <= 32'h0;
      s_done_q   <= 1'b0;
      k_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      sbuf_q     <= sbuf_d;
      kbuf_q     <= kbuf_d;
      last_key_q <= last_key_d;
      s_result_q <= s_result_d;
      k_result_q <= k_result_d;
      s_done_q   <= s_done_d;
      k_done_q   <= k_done_d;
    end
  end

  assign bus.s_ready  = s_ready_s;
  assign bus.k_ready  = k_ready_s;
  assign bus.s_done   = s_done_q;
  assign bus.k_done   = k_done_q;
  assign bus.s_result = s_result_q;
  assign bus.k_result = k_result_q;
  assign bus.sb_in    = sb_in_s;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_sched.sv
// Bench for sbox_sched: AES S-box model on the lanes, a job-level reference
// model compared every cycle, plus directed literal checks.
module tb_sbox_sched;

  logic clk;
  logic rst;
  sbox_sched_if bus();

  sbox_sched #(.KEY_FIRST(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [127:0] ST_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] ST_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  logic [31:0] sb_seq [4] = '{32'h193de3be, 32'ha0f4e22b, 32'h9ac68d2a, 32'he9f84808};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] d);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[32*w +: 32] = sub_word(d[32*w +: 32]);
    return r;
  endfunction

  assign bus.sb_out = sub_word(bus.sb_in);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Job-level reference model: kind 0 idle, 1 state job, 2 key job.
  int           m_kind = 0;
  int           m_idx = 0;
  logic [127:0] m_data = '0;
  logic [31:0]  m_kw = '0;
  logic         m_last_key = 1'b0;
  logic [127:0] m_sres = '0;
  logic [31:0]  m_kres = '0;
  logic         m_sdone = 1'b0;
  logic         m_kdone = 1'b0;
  bit           grants[$];

  always @(negedge clk) begin
    logic exp_sr, exp_kr, nsd, nkd;
    logic [31:0] exp_sb;
    if (rst) begin
      m_kind = 0; m_idx = 0; m_sres = '0; m_kres = '0;
      m_sdone = 1'b0; m_kdone = 1'b0; m_last_key = 1'b0;
    end
    exp_sr = (m_kind == 0) && (!bus.k_valid || m_last_key);
    exp_kr = (m_kind == 0) && (!bus.s_valid || !m_last_key);
    exp_sb = (m_kind == 1) ? 32'(m_data >> (32 * (3 - m_idx))) :
             (m_kind == 2) ? m_kw : 32'h0;
    check("busy", bus.busy, m_kind != 0);
    check("s_ready", bus.s_ready, exp_sr);
    check("k_ready", bus.k_ready, exp_kr);
    check("sb_in", bus.sb_in, exp_sb);
    check("s_done", bus.s_done, m_sdone);
    check("k_done", bus.k_done, m_kdone);
    check("k_result", bus.k_result, m_kres);
    if (m_kind != 1) check("s_result", bus.s_result, m_sres);
    if (!rst) begin
      nsd = 1'b0; nkd = 1'b0;
      if (m_kind == 1) begin
        if (m_idx == 3) begin
          m_sres = sub_state(m_data); nsd = 1'b1; m_kind = 0;
        end else m_idx++;
      end else if (m_kind == 2) begin
        m_kres = sub_word(m_kw); nkd = 1'b1; m_kind = 0;
      end else if (bus.s_valid && exp_sr) begin
        m_kind = 1; m_idx = 0; m_data = bus.s_data; m_last_key = 1'b0; grants.push_back(1'b0);
      end else if (bus.k_valid && exp_kr) begin
        m_kind = 2; m_kw = bus.k_word; m_last_key = 1'b1; grants.push_back(1'b1);
      end
      m_sdone = nsd; m_kdone = nkd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic state_job_literal();
    tick(); bus.s_data = ST_IN; bus.s_valid = 1'b1;
    tick(); bus.s_valid = 1'b0; bus.s_data = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sb_in_seq", bus.sb_in, sb_seq[i]);
    end
    @(negedge clk);
    check("s_done_lat5", bus.s_done, 1'b1);
    check("s_result_lit", bus.s_result, ST_OUT);
  endtask

  task automatic key_job_literal(input logic [31:0] w, input logic [31:0] exp_res);
    tick(); bus.k_word = w; bus.k_valid = 1'b1;
    tick(); bus.k_valid = 1'b0; bus.k_word = 32'hffffffff;
    @(negedge clk);
    check("k_sb_in", bus.sb_in, w);
    @(negedge clk);
    check("k_done_lat2", bus.k_done, 1'b1);
    check("k_result_lit", bus.k_result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sd_cnt;
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.k_valid = 1'b0; bus.k_word = '0;
    check("pin_sbox_cf", sub_word(32'hcf4f3c09), 32'h8a84eb01);
    check("pin_sbox_00", sub_word(32'h0), 32'h63636363);
    check("pin_state", sub_state(ST_IN), ST_OUT);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("idle_sb_in", bus.sb_in, 32'h0);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_s_ready", bus.s_ready, 1'b1);
    check("idle_k_ready", bus.k_ready, 1'b1);

    // Contention from reset release
    tick();
    rst = 1'b1;
    bus.s_data = ST_IN; bus.k_word = 32'hcf4f3c09; bus.s_valid = 1'b1; bus.k_valid = 1'b1;
    grants.delete();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 40 && grants.size() < 4; i++) tick();
    bus.s_valid = 1'b0; bus.k_valid = 1'b0;
    check("grant_count", grants.size(), 4);
    if (grants.size() >= 4) begin
      check("grant0_K", grants[0], 1'b1);
      check("grant1_S", grants[1], 1'b0);
      check("grant2_K", grants[2], 1'b1);
      check("grant3_S", grants[3], 1'b0);
    end
    repeat (6) tick();
    check("cont_k_result", bus.k_result, 32'h8a84eb01);
    check("cont_s_result", bus.s_result, ST_OUT);

    state_job_literal();
    key_job_literal(32'hcf4f3c09, 32'h8a84eb01);
    key_job_literal(32'h00000000, 32'h63636363);

    // Key request arrives during S_SUB beat 1
    tick(); bus.s_data = ST_IN; bus.s_valid = 1'b1;
    tick(); bus.s_valid = 1'b0;
    tick(); bus.k_word = 32'hcf4f3c09; bus.k_valid = 1'b1;
    @(negedge clk);
    check("busy_k_ready_low", bus.k_ready, 1'b0);
    tick(); tick(); tick();
    @(negedge clk);
    check("req_s_done", bus.s_done, 1'b1);
    check("req_k_ready_idle", bus.k_ready, 1'b1);
    tick(); bus.k_valid = 1'b0;
    tick();
    @(negedge clk);
    check("req_k_done", bus.k_done, 1'b1);
    check("req_k_result", bus.k_result, 32'h8a84eb01);
    check("req_s_result_kept", bus.s_result, ST_OUT);

    // Reset during S_SUB beat 2
    tick(); bus.s_data = ST_IN; bus.s_valid = 1'b1;
    tick(); bus.s_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_s_done", bus.s_done, 1'b0);
    check("rst_s_result", bus.s_result, 128'h0);
    check("rst_sb_in", bus.sb_in, 32'h0);
    tick();
    rst = 1'b0;
    sd_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.s_done) sd_cnt++;
    end
    check("no_done_after_rst", sd_cnt, 0);
    state_job_literal();

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
